// File: rtl/npu_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : npu_result_drain
// Purpose  : Waits a fixed compute latency after start, snapshots the NPU
//            result matrix, then streams it row-major on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module npu_result_drain #(
  parameter int N              = 2,
  parameter int OUT_W          = N + 15,
  parameter int COMPUTE_CYCLES = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N*N*OUT_W-1:0]   npu_out,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_W-1:0]       m_data,
  output logic [$clog2(N)-1:0]   m_row,
  output logic [$clog2(N)-1:0]   m_col,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done,
  output logic                   err_start
);

  localparam int ELEMS = N * N;
  localparam int IDX_W = $clog2(ELEMS);
  localparam int RC_W  = $clog2(N);
  localparam int CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ELEMS - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COMPUTE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [ELEMS*OUT_W-1:0] mat_buf;
  logic [OUT_W-1:0]       elem;
  logic                   is_last;

  assign elem    = mat_buf[int'(idx)*OUT_W +: OUT_W];
  assign is_last = (idx == LAST_IDX);

  // Stream outputs are zeroed when not valid so reset and idle read as 0.
  assign m_valid = (state == S_STREAM);
  assign busy    = (state != S_IDLE);
  assign m_data  = m_valid ? elem : '0;
  assign m_row   = m_valid ? RC_W'(idx / IDX_W'(N)) : '0;
  assign m_col   = m_valid ? RC_W'(idx % IDX_W'(N)) : '0;
  assign m_last  = m_valid && is_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      mat_buf   <= '0;
      done      <= 1'b0;
      err_start <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && (state != S_IDLE)) begin
        err_start <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT;
            cnt   <= CNT_LOAD;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            mat_buf <= npu_out;
            idx     <= '0;
            state   <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (m_ready) begin
            if (is_last) begin
              state <= S_IDLE;
              idx   <= '0;
              done  <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
